// File: rtl/omc_pchan_ctrl.sv
// P-Channel power-policy controller: arbitrates wake/software/idle-timeout requests into P-Channel handshakes.
// Latency: selection cycle N -> preq at N+1; accept/deny at M -> preq low at M+1; release at K -> pulse at K+1.
// Backpressure: sw_req_ready is high only in IDLE when no wake is selected; wake hints wait until IDLE.
module omc_pchan_ctrl #(
    parameter int unsigned IDLE_W     = 16,
    parameter logic [2:0]  RUN_PSTATE = 3'd0,
    parameter logic [2:0]  SR_PSTATE  = 3'd1,
    parameter logic [2:0]  PD_PSTATE  = 3'd2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              sw_req_valid,
    input  logic [2:0]        sw_req_state,
    output logic              sw_req_ready,
    input  logic              auto_en,
    input  logic [2:0]        auto_state,
    input  logic [IDLE_W-1:0] idle_thresh,
    input  logic              wake_req,
    output logic              preq,
    output logic [2:0]        pstate,
    input  logic              paccept,
    input  logic              pdeny,
    input  logic              pactive,
    output logic [2:0]        cur_state,
    output logic              busy,
    output logic              done_pulse,
    output logic              deny_pulse,
    output logic              err_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              preq_q, preq_d;
    logic [2:0]        pstate_q, pstate_d;
    logic [2:0]        cur_q, cur_d;
    logic              acc_q, acc_d;
    logic              busy_q;
    logic              done_q, done_d;
    logic              deny_q, deny_d;
    logic              err_q, err_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    logic              wake_sel;
    logic              auto_sel;
    logic              tgt_vld;
    logic [2:0]        tgt;
    logic              tgt_rsvd;
    logic              cnt_run;

    // Source selection in IDLE: wake beats software, software beats idle-timeout.
    always_comb begin
        wake_sel = wake_req && (cur_q != RUN_PSTATE);
        auto_sel = auto_en && (cur_q == RUN_PSTATE) && (idle_thresh != '0) &&
                   (idle_cnt_q >= idle_thresh) && !wake_req;
        tgt_vld  = 1'b0;
        tgt      = RUN_PSTATE;
        if (wake_sel) begin
            tgt_vld = 1'b1;
            tgt     = RUN_PSTATE;
        end else if (sw_req_valid) begin
            tgt_vld = 1'b1;
            tgt     = sw_req_state;
        end else if (auto_sel) begin
            tgt_vld = 1'b1;
            tgt     = auto_state;
        end
        tgt_rsvd = (tgt != RUN_PSTATE) && (tgt != SR_PSTATE) && (tgt != PD_PSTATE);
    end

    // Handshake sequencing and next-state of every registered output.
    always_comb begin
        state_d  = state_q;
        preq_d   = preq_q;
        pstate_d = pstate_q;
        cur_d    = cur_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        deny_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tgt_vld) begin
                    if (tgt == cur_q) begin
                        done_d = 1'b1;
                    end else if (tgt_rsvd) begin
                        err_d = 1'b1;
                    end else begin
                        pstate_d = tgt;
                        preq_d   = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // A simultaneous accept and deny is resolved as a deny.
                if (paccept || pdeny) begin
                    acc_d   = paccept && !pdeny;
                    if (paccept && !pdeny) begin
                        cur_d = pstate_q;
                    end
                    preq_d  = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // pstate is held until the slave has dropped both responses.
                if (!paccept && !pdeny) begin
                    pstate_d = cur_q;
                    done_d   = acc_q;
                    deny_d   = !acc_q;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                preq_d  = 1'b0;
            end
        endcase
    end

    // Idle counter runs only while quiescent in RUN and staying in IDLE; saturates at all-ones.
    always_comb begin
        cnt_run = (state_q == ST_IDLE) && (state_d == ST_IDLE) && (cur_q == RUN_PSTATE) &&
                  !pactive && !wake_req;
        if (!cnt_run) begin
            idle_cnt_d = '0;
        end else if (&idle_cnt_q) begin
            idle_cnt_d = idle_cnt_q;
        end else begin
            idle_cnt_d = idle_cnt_q + {{(IDLE_W-1){1'b0}}, 1'b1};
        end
    end

    // State and output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            preq_q     <= 1'b0;
            pstate_q   <= RUN_PSTATE;
            cur_q      <= RUN_PSTATE;
            acc_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            deny_q     <= 1'b0;
            err_q      <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            preq_q     <= preq_d;
            pstate_q   <= pstate_d;
            cur_q      <= cur_d;
            acc_q      <= acc_d;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= done_d;
            deny_q     <= deny_d;
            err_q      <= err_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Ready is held low while reset is asserted.
    assign sw_req_ready = aresetn && (state_q == ST_IDLE) && !wake_sel;
    assign preq         = preq_q;
    assign pstate       = pstate_q;
    assign cur_state    = cur_q;
    assign busy         = busy_q;
    assign done_pulse   = done_q;
    assign deny_pulse   = deny_q;
    assign err_pulse    = err_q;

endmodule

// File: tb/tb_omc_pchan_ctrl.sv
// Bench for omc_pchan_ctrl: directed scenarios plus randomized traffic against a cycle reference model.
// Latency: model advances on each aclk rising edge; outputs compared on every falling edge.
// Backpressure: OMC slave responder emulated here with directed or random accept/deny timing.
module tb_omc_pchan_ctrl;

    logic        aclk;
    logic        aresetn;
    logic        sw_req_valid;
    logic [2:0]  sw_req_state;
    logic        sw_req_ready;
    logic        auto_en;
    logic [2:0]  auto_state;
    logic [15:0] idle_thresh;
    logic        wake_req;
    logic        preq;
    logic [2:0]  pstate;
    logic        paccept;
    logic        pdeny;
    logic        pactive;
    logic [2:0]  cur_state;
    logic        busy;
    logic        done_pulse;
    logic        deny_pulse;
    logic        err_pulse;

    int total = 0;
    int bad   = 0;

    omc_pchan_ctrl dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .sw_req_valid(sw_req_valid),
        .sw_req_state(sw_req_state),
        .sw_req_ready(sw_req_ready),
        .auto_en     (auto_en),
        .auto_state  (auto_state),
        .idle_thresh (idle_thresh),
        .wake_req    (wake_req),
        .preq        (preq),
        .pstate      (pstate),
        .paccept     (paccept),
        .pdeny       (pdeny),
        .pactive     (pactive),
        .cur_state   (cur_state),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .deny_pulse  (deny_pulse),
        .err_pulse   (err_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = requesting, 2 = waiting for slave release.
    int m_phase = 0;
    int m_cur   = 0;
    int m_pst   = 0;
    int m_preq  = 0;
    int m_done  = 0;
    int m_deny  = 0;
    int m_err   = 0;
    int m_acc   = 0;
    int m_cnt   = 0;
    int m_tgt;
    int m_have;
    int m_leave;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_phase = 0; m_cur = 0; m_pst = 0; m_preq = 0;
            m_done = 0; m_deny = 0; m_err = 0; m_acc = 0; m_cnt = 0;
        end else begin
            m_done = 0; m_deny = 0; m_err = 0; m_leave = 0;
            if (m_phase == 0) begin
                m_have = 1;
                m_tgt  = 0;
                if (wake_req && m_cur != 0) m_tgt = 0;
                else if (sw_req_valid) m_tgt = int'(sw_req_state);
                else if (auto_en && m_cur == 0 && idle_thresh != 0 &&
                         m_cnt >= int'(idle_thresh) && !wake_req) m_tgt = int'(auto_state);
                else m_have = 0;
                if (m_have != 0) begin
                    if (m_tgt == m_cur) m_done = 1;
                    else if (m_tgt > 2) m_err = 1;
                    else begin
                        m_pst = m_tgt; m_preq = 1; m_phase = 1; m_leave = 1;
                    end
                end
                if (m_leave != 0 || m_cur != 0 || pactive || wake_req) m_cnt = 0;
                else if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else if (m_phase == 1) begin
                m_cnt = 0;
                if (paccept || pdeny) begin
                    m_acc = (paccept && !pdeny) ? 1 : 0;
                    if (m_acc != 0) m_cur = m_pst;
                    m_preq  = 0;
                    m_phase = 2;
                end
            end else begin
                m_cnt = 0;
                if (!paccept && !pdeny) begin
                    m_pst = m_cur;
                    if (m_acc != 0) m_done = 1; else m_deny = 1;
                    m_phase = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus event counters for directed checks.
    int n_done = 0;
    int n_deny = 0;
    int n_err  = 0;
    int n_rise = 0;
    logic prev_preq = 1'b0;

    always @(negedge aclk) begin
        chk("preq", preq, m_preq);
        chk("pstate", pstate, m_pst);
        chk("cur_state", cur_state, m_cur);
        chk("busy", busy, (m_phase != 0) ? 1 : 0);
        chk("done_pulse", done_pulse, m_done);
        chk("deny_pulse", deny_pulse, m_deny);
        chk("err_pulse", err_pulse, m_err);
        chk("sw_req_ready", sw_req_ready,
            (aresetn && m_phase == 0 && !(wake_req && m_cur != 0)) ? 1 : 0);
        if (aresetn) begin
            if (done_pulse) n_done++;
            if (deny_pulse) n_deny++;
            if (err_pulse)  n_err++;
            if (preq && !prev_preq) n_rise++;
        end
        prev_preq = preq;
    end

    // OMC slave emulation. Modes: 0 accept after delay, 1 deny after delay, 2 random, 3 never answer.
    int resp_mode  = 0;
    int resp_delay = 0;
    int r_cnt      = 0;
    int r_hold     = 0;
    int r_sel;
    bit r_go;

    initial begin
        paccept = 1'b0;
        pdeny   = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (!aresetn) begin
                paccept = 1'b0; pdeny = 1'b0; r_cnt = 0; r_hold = 0;
            end else if (paccept || pdeny) begin
                if (!preq) begin
                    if (r_hold == 0) begin paccept = 1'b0; pdeny = 1'b0; end
                    else r_hold--;
                end
            end else if (preq && resp_mode != 3) begin
                if (resp_mode == 2) r_go = ($urandom % 3) == 0;
                else r_go = (r_cnt >= resp_delay);
                if (r_go) begin
                    r_cnt  = 0;
                    r_hold = 0;
                    if (resp_mode == 0) paccept = 1'b1;
                    else if (resp_mode == 1) pdeny = 1'b1;
                    else begin
                        r_sel = $urandom % 8;
                        if (r_sel < 4) paccept = 1'b1;
                        else if (r_sel < 7) pdeny = 1'b1;
                        else begin paccept = 1'b1; pdeny = 1'b1; end
                        r_hold = $urandom % 3;
                    end
                end else begin
                    r_cnt++;
                end
            end
        end
    end

    task automatic clr_counts();
        n_done = 0; n_deny = 0; n_err = 0; n_rise = 0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk); #1;
        end
    endtask

    // Present a software request; returns #1 after the edge on which it was accepted.
    task automatic sw_send(input logic [2:0] st);
        bit ok;
        ok = 0;
        sw_req_valid = 1'b1;
        sw_req_state = st;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge aclk);
            if (sw_req_ready) ok = 1;
            @(posedge aclk); #1;
        end
        sw_req_valid = 1'b0;
        if (!ok) chk("sw_accept_timeout", 0, 1);
    endtask

    // Wait (bounded) for any completion/deny/error pulse to have been counted.
    task automatic wait_pulse(input string nm);
        int i;
        i = 0;
        while ((n_done + n_deny + n_err) == 0 && i < 80) begin
            @(posedge aclk); #1;
            i++;
        end
        if (i >= 80) chk(nm, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        aresetn      = 1'b0;
        sw_req_valid = 1'b0;
        sw_req_state = 3'd0;
        auto_en      = 1'b0;
        auto_state   = 3'd0;
        idle_thresh  = 16'd0;
        wake_req     = 1'b0;
        pactive      = 1'b0;
        resp_mode    = 0;
        resp_delay   = 0;

        // Reset state, ready held low while in reset, then quiet for 10 cycles.
        cycles(3);
        chk("reset_ready", sw_req_ready, 0);
        chk("reset_preq", preq, 0);
        aresetn = 1'b1;
        clr_counts();
        cycles(10);
        chk("post_reset_preq", preq, 0);
        chk("post_reset_pstate", pstate, 3'd0);
        chk("post_reset_cur", cur_state, 3'd0);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_pulses", n_done + n_deny + n_err, 0);
        chk("post_reset_ready", sw_req_ready, 1);

        // Software request to self-refresh, accepted after 3 cycles.
        resp_mode = 0; resp_delay = 3;
        clr_counts();
        sw_send(3'd1);
        chk("sr_preq_next", preq, 1);
        chk("sr_pstate", pstate, 3'd1);
        wait_pulse("sr_timeout");
        cycles(3);
        chk("sr_done_once", n_done, 1);
        chk("sr_no_deny", n_deny, 0);
        chk("sr_cur", cur_state, 3'd1);
        chk("sr_pstate_after", pstate, 3'd1);
        chk("sr_busy", busy, 0);

        // Power-down request from self-refresh, denied.
        resp_mode = 1; resp_delay = 1;
        clr_counts();
        sw_send(3'd2);
        chk("pd_pstate_req", pstate, 3'd2);
        wait_pulse("pd_timeout");
        cycles(3);
        chk("pd_deny_once", n_deny, 1);
        chk("pd_no_done", n_done, 0);
        chk("pd_cur", cur_state, 3'd1);
        chk("pd_pstate_back", pstate, 3'd1);

        // Wake and software request in the same cycle: wake wins.
        resp_mode = 0; resp_delay = 1;
        clr_counts();
        wake_req = 1'b1; sw_req_valid = 1'b1; sw_req_state = 3'd2;
        @(negedge aclk);
        chk("wake_ready_low", sw_req_ready, 0);
        @(posedge aclk); #1;
        sw_req_valid = 1'b0;
        chk("wake_preq", preq, 1);
        chk("wake_pstate", pstate, 3'd0);
        wait_pulse("wake_timeout");
        wake_req = 1'b0;
        cycles(2);
        chk("wake_done", n_done, 1);
        chk("wake_cur", cur_state, 3'd0);
        chk("wake_rises", n_rise, 1);

        // Reserved state is dropped with an error; same-state request completes without a handshake.
        clr_counts();
        sw_send(3'd5);
        cycles(3);
        chk("rsvd_err_once", n_err, 1);
        chk("rsvd_no_preq", n_rise, 0);
        clr_counts();
        sw_send(3'd0);
        cycles(3);
        chk("same_done_once", n_done, 1);
        chk("same_no_preq", n_rise, 0);

        // Idle-timeout auto entry, threshold 20.
        resp_mode = 0; resp_delay = 0;
        pactive = 1'b1;
        cycles(1);
        auto_en = 1'b1; auto_state = 3'd1; idle_thresh = 16'd20;
        cycles(1);
        pactive = 1'b0;
        n = 0;
        while (!preq && n < 80) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("auto_delay_in_range", (n >= 21 && n <= 22) ? 1 : 0, 1);
        chk("auto_pstate", pstate, 3'd1);
        clr_counts();
        wait_pulse("auto_timeout");
        auto_en = 1'b0;
        cycles(1);
        chk("auto_cur", cur_state, 3'd1);
        clr_counts();
        wake_req = 1'b1;
        wait_pulse("auto_wake_timeout");
        wake_req = 1'b0;

        // Same again with one cycle of pactive ten cycles in: count restarts.
        pactive = 1'b1;
        cycles(1);
        auto_en = 1'b1;
        cycles(1);
        pactive = 1'b0;
        n = 0;
        while (!preq && n < 100) begin
            @(posedge aclk); #1;
            n++;
            if (n == 10) pactive = 1'b1;
            if (n == 11) pactive = 1'b0;
        end
        chk("auto_restart_in_range", (n >= 32 && n <= 33) ? 1 : 0, 1);
        clr_counts();
        wait_pulse("auto2_timeout");
        auto_en = 1'b0;
        wake_req = 1'b1;
        cycles(1);
        clr_counts();
        wait_pulse("auto2_wake_timeout");
        wake_req = 1'b0;

        // Randomized traffic, checked every cycle by the model.
        resp_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                auto_en     = $urandom % 2;
                idle_thresh = 16'($urandom % 9);
                auto_state  = 3'($urandom % 4);
            end
            wake_req     = ($urandom % 10) == 0;
            pactive      = ($urandom % 5) == 0;
            sw_req_valid = ($urandom % 6) == 0;
            sw_req_state = (($urandom % 8) == 0) ? 3'($urandom % 8) : 3'($urandom % 3);
            cycles(1);
        end

        // Asynchronous reset in the middle of a handshake.
        sw_req_valid = 1'b0; wake_req = 1'b0; auto_en = 1'b0; pactive = 1'b0;
        n = 0;
        while ((m_phase != 0 || paccept || pdeny) && n < 100) begin
            cycles(1);
            n++;
        end
        resp_mode = 3;
        sw_send((m_cur == 1) ? 3'd2 : 3'd1);
        chk("arst_preq_before", preq, 1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_preq_drop", preq, 0);
        chk("arst_cur", cur_state, 3'd0);
        chk("arst_busy", busy, 0);
        cycles(2);
        aresetn = 1'b1;
        resp_mode = 0; resp_delay = 0;
        clr_counts();
        cycles(10);
        chk("arst_quiet", n_done + n_deny + n_err + n_rise, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
